// File: rtl/core_ex_fwd_pkg.sv
// Shared widths and per-stage forwarding descriptor for the EX operand-forwarding slot.
package core_ex_fwd_pkg;
  localparam int REG_AW = 5;
  localparam int CSR_AW = 12;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  // Addressing/control view of one producer stage; result data stays in the
  // XLEN-wide port vectors because XLEN is a per-instance parameter.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              data_valid;
    logic [CSR_AW-1:0] csr;
    logic              csr_write;
  } fwd_stage_t;
endpackage

// File: rtl/core_ex_fwd_lookup.sv
// Priority matcher: the lowest-index (youngest) stage writing addr wins.
module core_ex_fwd_lookup #(
  parameter int AW     = 5,
  parameter int NSTAGE = 2,
  parameter int DW     = 32
) (
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  input  logic [NSTAGE*AW-1:0] st_addr,
  input  logic [NSTAGE-1:0]    st_write,
  input  logic [NSTAGE-1:0]    st_ready,
  input  logic [NSTAGE*DW-1:0] st_data,
  output logic                 hit,
  output logic                 ready,
  output logic [DW-1:0]        data
);
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    data  = '0;
    // Scan oldest to youngest so the youngest match overwrites.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (en && st_write[k] && (st_addr[k*AW +: AW] == addr)) begin
        hit   = 1'b1;
        ready = st_ready[k];
        data  = st_data[k*DW +: DW];
      end
    end
  end
endmodule

// File: rtl/core_ex_fwd_slot.sv
// One-entry operand-forwarding slot between ID/EX and EX; waits on producers
// whose data is not yet valid and presents fully resolved operands.
module core_ex_fwd_slot
  import core_ex_fwd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NSRC   = 2,
  parameter int NSTAGE = 2,
  parameter int PW     = 64,
  parameter int CNTW   = 16
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*REG_AW-1:0] in_rs,
  input  logic [NSRC-1:0]        in_rs_valid,
  input  logic [NSRC*XLEN-1:0]   in_rs_value,
  input  logic [CSR_AW-1:0]      in_csr,
  input  logic                   in_csr_valid,
  input  logic [XLEN-1:0]        in_csr_value,
  input  logic [PW-1:0]          in_payload,
  input  logic [NSTAGE*REG_AW-1:0] fw_rd,
  input  logic [NSTAGE-1:0]      fw_reg_write,
  input  logic [NSTAGE*XLEN-1:0] fw_data,
  input  logic [NSTAGE-1:0]      fw_data_valid,
  input  logic [NSTAGE*CSR_AW-1:0] fw_csr,
  input  logic [NSTAGE-1:0]      fw_csr_write,
  input  logic [NSTAGE*XLEN-1:0] fw_csr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NSRC*XLEN-1:0]   out_rs_value,
  output logic [XLEN-1:0]        out_csr_value,
  output logic [PW-1:0]          out_payload,
  output logic                   hazard_stall,
  output logic [CNTW-1:0]        stall_cnt
);
  fwd_stage_t                 st [NSTAGE];
  logic [NSTAGE*REG_AW-1:0]   st_rd;
  logic [NSTAGE*CSR_AW-1:0]   st_csr;
  logic [NSTAGE-1:0]          st_rw, st_dv, st_cw;

  logic                       slot_valid;
  logic [NSRC-1:0]            pend;
  logic [NSRC*REG_AW-1:0]     rs_q;
  logic                       accept;
  logic [NSRC-1:0]            r_hit, r_rdy;
  logic [NSRC*XLEN-1:0]       r_data;
  logic                       c_hit, c_rdy;
  logic [XLEN-1:0]            c_data;

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      st[k].rd         = fw_rd[k*REG_AW +: REG_AW];
      st[k].reg_write  = fw_reg_write[k];
      st[k].data_valid = fw_data_valid[k];
      st[k].csr        = fw_csr[k*CSR_AW +: CSR_AW];
      st[k].csr_write  = fw_csr_write[k];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      st_rd[k*REG_AW +: REG_AW]  = st[k].rd;
      st_rw[k]                   = st[k].reg_write;
      st_dv[k]                   = st[k].data_valid;
      st_csr[k*CSR_AW +: CSR_AW] = st[k].csr;
      st_cw[k]                   = st[k].csr_write;
    end
  end

  // Handshake: a transfer happens on a cycle where valid && ready are both high;
  // valid never depends on ready, and an offered item holds until it transfers.
  // Flush raises in_ready but the offered instruction is dropped.
  assign out_valid    = slot_valid && (pend == '0);
  assign hazard_stall = slot_valid && (pend != '0);
  assign in_ready     = flush || !slot_valid || (out_valid && out_ready);
  assign accept       = in_valid && in_ready && !flush;

  // Lookups watch the incoming instruction at accept, otherwise the held indices.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [REG_AW-1:0] addr;
    logic              en;
    assign addr = accept ? in_rs[i*REG_AW +: REG_AW] : rs_q[i*REG_AW +: REG_AW];
    assign en   = accept ? (in_rs_valid[i] && (addr != REG_X0)) : pend[i];
    core_ex_fwd_lookup #(.AW(REG_AW), .NSTAGE(NSTAGE), .DW(XLEN)) u_lookup (
      .en       (en),
      .addr     (addr),
      .st_addr  (st_rd),
      .st_write (st_rw),
      .st_ready (st_dv),
      .st_data  (fw_data),
      .hit      (r_hit[i]),
      .ready    (r_rdy[i]),
      .data     (r_data[i*XLEN +: XLEN])
    );
  end

  core_ex_fwd_lookup #(.AW(CSR_AW), .NSTAGE(NSTAGE), .DW(XLEN)) u_csr_lookup (
    .en       (in_csr_valid),
    .addr     (in_csr),
    .st_addr  (st_csr),
    .st_write (st_cw),
    .st_ready ({NSTAGE{1'b1}}),
    .st_data  (fw_csr_data),
    .hit      (c_hit),
    .ready    (c_rdy),
    .data     (c_data)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      slot_valid    <= 1'b0;
      pend          <= '0;
      rs_q          <= '0;
      out_rs_value  <= '0;
      out_csr_value <= '0;
      out_payload   <= '0;
      stall_cnt     <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != {CNTW{1'b1}}))
        stall_cnt <= stall_cnt + CNTW'(1);
      if (flush) begin
        slot_valid <= 1'b0;
        pend       <= '0;
      end else if (accept) begin
        slot_valid  <= 1'b1;
        rs_q        <= in_rs;
        out_payload <= in_payload;
        for (int i = 0; i < NSRC; i++) begin
          if (r_hit[i] && !r_rdy[i]) begin
            pend[i] <= 1'b1;
          end else begin
            pend[i] <= 1'b0;
            out_rs_value[i*XLEN +: XLEN] <= r_hit[i] ? r_data[i*XLEN +: XLEN]
                                                     : in_rs_value[i*XLEN +: XLEN];
          end
        end
        out_csr_value <= (c_hit && c_rdy) ? c_data : in_csr_value;
      end else begin
        if (out_valid && out_ready)
          slot_valid <= 1'b0;
        for (int i = 0; i < NSRC; i++) begin
          if (pend[i] && r_hit[i] && r_rdy[i]) begin
            pend[i] <= 1'b0;
            out_rs_value[i*XLEN +: XLEN] <= r_data[i*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // A waiting operand must always find its producer in some stage.
  a_pending_has_producer: assert property (@(posedge clk) disable iff (rest)
    !(slot_valid && !flush && ((pend & ~r_hit) != '0)));
endmodule
